instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter: INSTR_W, default 16, instruction word width in bits.
REQ-002 Parameter: DEPTH, fixed at 4 entries; pointers 2 bits, count 3 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc_in  input  10  current PC from the fetch unit.
REQ-006 pc_valid  input  1  pc_in is a fetch request this cycle.
REQ-007 flush  input  1  branch/jump redirect; discard all queued and in-flight instructions.
REQ-008 imem_addr  output  10  instruction memory address; equals pc_in combinationally.
REQ-009 imem_rd  output  1  instruction memory read strobe.
REQ-010 imem_rdata  input  INSTR_W  memory data, valid the cycle after imem_rd was sampled high.
REQ-011 deq_ready  input  1  decode stage accepts the head entry this cycle.
REQ-012 out_valid  output  1  head entry valid (equals !empty).
REQ-013 out_instr  output  INSTR_W  head entry instruction.
REQ-014 out_pc  output  10  head entry PC.
REQ-015 stall  output  1  fetch unit shall hold its PC while high.
REQ-016 count  output  3  number of valid entries, 0..4.
REQ-017 full / empty  output  1 each  count==4 / count==0.

Function
REQ-018 The block shall set imem_rd = pc_valid & !stall & !flush, combinationally.
REQ-019 On each edge with imem_rd high, the block shall set inflight=1 and capture pc_in into pend_pc; otherwise it shall clear inflight.
REQ-020 On an edge with inflight=1 and flush=0, the block shall write {pend_pc, imem_rdata} at wr_ptr and increment wr_ptr.
REQ-021 Latency: pc_valid high in cycle t (no stall) shall give out_valid high with that PC in cycle t+2.
REQ-022 The block shall assert stall = (count + inflight) >= 4, combinationally, ignoring same-cycle deq_ready (conservative credit).
REQ-023 Credit stall shall prevent any write to a full queue; a write when full is a design error and shall never occur.
REQ-024 Dequeue shall occur on an edge with deq_ready=1, empty=0 and flush=0, incrementing rd_ptr; deq_ready while empty shall be ignored.
REQ-025 Simultaneous enqueue and dequeue shall leave count unchanged and advance both pointers.
REQ-026 Pointers shall wrap modulo 4 (3 -> 0) with no other side effect.
REQ-027 out_instr/out_pc shall be driven from the entry at rd_ptr, with no bypass from imem_rdata to the outputs.
REQ-028 flush shall have priority over all other events: on that edge, count, wr_ptr and rd_ptr shall go to 0, inflight shall clear, and the concurrent imem_rdata shall be dropped.
REQ-029 The cycle after a flush, the block shall accept the redirected pc_in normally (pc_valid=1 gives imem_rd=1, since stall=0).
REQ-030 Contents of entries that are not valid are don't-care, but out_instr/out_pc shall not contain X after reset.

Reset
REQ-031 Reset low shall immediately, independent of clk, set count=0, wr_ptr=rd_ptr=0, inflight=0, pend_pc=0, and all entry storage to 0.
REQ-032 During reset: out_valid=0, empty=1, full=0, stall=0, out_instr=0, out_pc=0, imem_rd=pc_valid & !flush.
REQ-033 Reset asserted mid-operation shall discard the queue and any in-flight read, with no entry written on the following edge.
REQ-034 After reset deasserts, the first rising edge shall behave as a normal cycle.

Verification
REQ-035 Stream: reset, then pc_in 0,1,2,3 with pc_valid=1, deq_ready=1 -> out_pc 0,1,2,3 appear in consecutive cycles starting 2 cycles after PC 0; count stays <=1.
REQ-036 Fill: deq_ready=0, pc_in 10..15 -> stall rises when count+inflight=4; queue holds PCs 10,11,12,13; imem_rd low while stalled; full=1.
REQ-037 Drain/wrap: from full, deq_ready=1 for 6 cycles while fetching 14,15 -> output order 10,11,12,13,14,15 across pointer wrap; empty=1 afterwards.
REQ-038 Flush: 3 entries queued plus 1 in flight, flush=1 for one cycle with pc_in=100 -> next cycle count=0, out_valid=0; PC 100 fetched next emerges as the first out_pc.
REQ-039 Simultaneous events: count=2 with enqueue and deq_ready in the same cycle -> count stays 2; with flush also high -> count=0.
REQ-040 Async reset: reset pulsed low between clock edges with count=3 -> outputs reach their reset values before the next edge, and there is no enqueue on that edge.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue.
// The queue uses the slave modport. The fetch unit, memory and decode stage use the master modport.
interface instr_fetch_queue_if #(
   parameter int INSTR_W = 16
);
   logic [9:0]         pc_in;
   logic               pc_valid;
   logic               flush;
   logic [9:0]         imem_addr;
   logic               imem_rd;
   logic [INSTR_W-1:0] imem_rdata;
   logic               deq_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [9:0]         out_pc;
   logic               stall;
   logic [2:0]         count;
   logic               full;
   logic               empty;

   modport slave (
      input  pc_in, pc_valid, flush, imem_rdata, deq_ready,
      output imem_addr, imem_rd, out_valid, out_instr, out_pc, stall, count, full, empty
   );

   modport master (
      output pc_in, pc_valid, flush, imem_rdata, deq_ready,
      input  imem_addr, imem_rd, out_valid, out_instr, out_pc, stall, count, full, empty
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Four-entry instruction prefetch queue with one memory read in flight.
// Credit-based stall counts the in-flight read, so the queue never overflows.
module instr_fetch_queue #(
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4
) (
   input logic                  clk,
   input logic                  reset,
   instr_fetch_queue_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [2:0]         count_reg;
   logic               inflight_reg;
   logic [9:0]         pend_pc_reg;
   logic [9:0]         mem_pc_reg    [DEPTH];
   logic [INSTR_W-1:0] mem_instr_reg [DEPTH];

   logic stall_next;
   logic do_rd;
   logic do_wr;
   logic do_deq;

   // The stall does not consider a dequeue in the same cycle, so the credit check stays conservative.
   assign stall_next = ({1'b0, count_reg} + {3'b000, inflight_reg}) >= 4'd4;
   assign do_rd      = bus.pc_valid & ~stall_next & ~bus.flush;
   assign do_wr      = inflight_reg & ~bus.flush;
   assign do_deq     = bus.deq_ready & (count_reg != 3'd0) & ~bus.flush;

   assign bus.imem_addr = bus.pc_in;
   assign bus.imem_rd   = do_rd;
   assign bus.stall     = stall_next;
   assign bus.count     = count_reg;
   assign bus.full      = (count_reg == 3'd4);
   assign bus.empty     = (count_reg == 3'd0);
   assign bus.out_valid = (count_reg != 3'd0);
   assign bus.out_pc    = mem_pc_reg[rd_ptr_reg];
   assign bus.out_instr = mem_instr_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= 3'd0;
         inflight_reg <= 1'b0;
         pend_pc_reg  <= 10'd0;
      end else if (bus.flush) begin
         // A redirect drops queued entries and the read data returning on this edge.
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= 3'd0;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= do_rd;
         if (do_rd) begin
            pend_pc_reg <= bus.pc_in;
         end
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_deq) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_wr, do_deq})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               mem_pc_reg[gi]    <= 10'd0;
               mem_instr_reg[gi] <= '0;
            end else if (do_wr && (wr_ptr_reg == PTR_W'(gi))) begin
               mem_pc_reg[gi]    <= pend_pc_reg;
               mem_instr_reg[gi] <= bus.imem_rdata;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and random stimulus for instr_fetch_queue.
// The reference model keeps the queue contents as PC and instruction lists, plus one pending read.
module tb_instr_fetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_queue_if #(.INSTR_W(16)) bus ();

   instr_fetch_queue #(.INSTR_W(16), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0]  q_pc  [$];
   logic [15:0] q_ins [$];
   bit          pend = 1'b0;
   logic [9:0]  pend_pc = 10'd0;

   function automatic logic [15:0] mem_word(input logic [9:0] a);
      logic [31:0] t;
      t = {22'd0, a} * 32'h0000_9E37;
      return t[15:0] ^ 16'hA55A;
   endfunction

   // Instruction memory: read data arrives one cycle after the strobe is sampled.
   always @(posedge clk) begin
      bus.imem_rdata <= bus.imem_rd ? mem_word(bus.imem_addr) : 16'($urandom);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_and_step(output bit accepted);
      int n;
      bit exp_stall;
      bit exp_rd;
      @(negedge clk);
      n         = q_pc.size();
      exp_stall = (n + int'(pend)) >= 4;
      exp_rd    = bus.pc_valid && !exp_stall && !bus.flush;
      check_eq("count",     32'(bus.count),     32'(n));
      check_eq("out_valid", 32'(bus.out_valid), 32'(n != 0));
      check_eq("empty",     32'(bus.empty),     32'(n == 0));
      check_eq("full",      32'(bus.full),      32'(n == 4));
      check_eq("stall",     32'(bus.stall),     32'(exp_stall));
      check_eq("imem_rd",   32'(bus.imem_rd),   32'(exp_rd));
      check_eq("imem_addr", 32'(bus.imem_addr), 32'(bus.pc_in));
      if (n > 0) begin
         check_eq("out_pc",    32'(bus.out_pc),    32'(q_pc[0]));
         check_eq("out_instr", 32'(bus.out_instr), 32'(q_ins[0]));
      end
      if (bus.flush) begin
         q_pc.delete();
         q_ins.delete();
         $display("flush pc_in=%0d", bus.pc_in);
      end else begin
         if (bus.deq_ready && n > 0) begin
            $display("deq pc=%0d instr=%04h", q_pc[0], q_ins[0]);
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (pend) begin
            q_pc.push_back(pend_pc);
            q_ins.push_back(mem_word(pend_pc));
         end
      end
      pend     = exp_rd;
      pend_pc  = bus.pc_in;
      accepted = exp_rd;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit pv, input logic [9:0] pc, input bit fl, input bit dq, output bit acc);
      bus.pc_valid  = pv;
      bus.pc_in     = pc;
      bus.flush     = fl;
      bus.deq_ready = dq;
      check_and_step(acc);
   endtask

   // Pulse the reset low between clock edges and check the outputs before the next edge.
   task automatic reset_pulse(input bit pv);
      bit acc;
      bus.pc_valid  = pv;
      bus.pc_in     = 10'd77;
      bus.flush     = 1'b0;
      bus.deq_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_empty",     32'(bus.empty),     32'd1);
      check_eq("rst_full",      32'(bus.full),      32'd0);
      check_eq("rst_stall",     32'(bus.stall),     32'd0);
      check_eq("rst_count",     32'(bus.count),     32'd0);
      check_eq("rst_out_instr", 32'(bus.out_instr), 32'd0);
      check_eq("rst_out_pc",    32'(bus.out_pc),    32'd0);
      check_eq("rst_imem_rd",   32'(bus.imem_rd),   32'(pv));
      #1 reset = 1'b1;
      q_pc.delete();
      q_ins.delete();
      pend = 1'b0;
      $display("reset pulse");
      check_and_step(acc);
   endtask

   initial begin
      bit acc;
      logic [9:0] pc;
      bus.pc_valid  = 1'b1;
      bus.pc_in     = 10'd5;
      bus.flush     = 1'b0;
      bus.deq_ready = 1'b0;
      #2;
      check_eq("init_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("init_empty",     32'(bus.empty),     32'd1);
      check_eq("init_full",      32'(bus.full),      32'd0);
      check_eq("init_stall",     32'(bus.stall),     32'd0);
      check_eq("init_out_instr", 32'(bus.out_instr), 32'd0);
      check_eq("init_out_pc",    32'(bus.out_pc),    32'd0);
      check_eq("init_imem_rd",   32'(bus.imem_rd),   32'd1);
      @(posedge clk);
      #1 reset = 1'b1;

      // Stream four PCs with the decode stage always ready.
      for (int i = 0; i < 4; i++) cycle(1'b1, 10'(i), 1'b0, 1'b1, acc);
      repeat (4) cycle(1'b0, 10'd0, 1'b0, 1'b1, acc);

      // Fill the queue with the decode stage stalled. The fetch unit holds the PC while stalled.
      pc = 10'd10;
      repeat (8) begin
         cycle(1'b1, pc, 1'b0, 1'b0, acc);
         if (acc) pc = pc + 10'd1;
      end
      check_eq("fill_full",  32'(bus.full),  32'd1);
      check_eq("fill_count", 32'(bus.count), 32'd4);

      // Drain across the pointer wrap while fetching the remaining PCs.
      repeat (6) begin
         cycle(pc <= 10'd15, pc, 1'b0, 1'b1, acc);
         if (acc) pc = pc + 10'd1;
      end
      repeat (3) cycle(1'b0, 10'd0, 1'b0, 1'b1, acc);
      check_eq("drain_empty", 32'(bus.empty), 32'd1);

      // Flush with three entries queued and one read in flight.
      for (int p = 20; p < 24; p++) cycle(1'b1, 10'(p), 1'b0, 1'b0, acc);
      check_eq("preflush_count", 32'(bus.count), 32'd3);
      cycle(1'b1, 10'd100, 1'b1, 1'b0, acc);
      check_eq("flush_count", 32'(bus.count), 32'd0);
      cycle(1'b1, 10'd100, 1'b0, 1'b0, acc);
      repeat (4) cycle(1'b0, 10'd0, 1'b0, 1'b1, acc);

      // Enqueue and dequeue in the same cycle, then the same with a flush.
      cycle(1'b1, 10'd30, 1'b0, 1'b0, acc);
      cycle(1'b1, 10'd31, 1'b0, 1'b0, acc);
      cycle(1'b0, 10'd0,  1'b0, 1'b0, acc);
      cycle(1'b1, 10'd32, 1'b0, 1'b0, acc);
      cycle(1'b0, 10'd0,  1'b0, 1'b1, acc);
      check_eq("simul_count", 32'(bus.count), 32'd2);
      cycle(1'b1, 10'd33, 1'b0, 1'b0, acc);
      cycle(1'b0, 10'd0,  1'b1, 1'b1, acc);
      check_eq("simul_flush_count", 32'(bus.count), 32'd0);

      // Asynchronous reset with three entries queued and one read in flight.
      for (int p = 40; p < 44; p++) cycle(1'b1, 10'(p), 1'b0, 1'b0, acc);
      check_eq("prerst_count", 32'(bus.count), 32'd3);
      reset_pulse(1'b0);
      check_eq("rst_no_enq", 32'(bus.count), 32'd0);

      // Random traffic. The fetch unit advances the PC only when a read is accepted.
      pc = 10'($urandom);
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(99) == 0) begin
            reset_pulse(1'($urandom_range(1)));
         end else begin
            cycle($urandom_range(3) != 0, pc, $urandom_range(19) == 0,
                  1'($urandom_range(1)), acc);
            if (acc) pc = pc + 10'd1;
            else if (bus.flush) pc = 10'($urandom);
         end
      end
      repeat (6) cycle(1'b0, 10'd0, 1'b0, 1'b1, acc);
      check_eq("final_empty", 32'(bus.empty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
